// File: rtl/aes_iter_core.sv
// Iterative AES-128 encryption core.
// ROUNDS_PER_CYCLE combinational rounds are chained and reused over
// 10/ROUNDS_PER_CYCLE clocks. The round key is expanded on the fly
// alongside the state. Valid/ready handshake on both sides; a new
// block can be accepted in the same cycle the previous result is taken.
module aes_iter_core #(
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input  logic         i_aes_iter_core_clk,
  input  logic         i_aes_iter_core_rst_n,
  input  logic         i_aes_iter_core_valid,
  output logic         o_aes_iter_core_ready,
  input  logic [127:0] i_aes_iter_core_plain_text,
  input  logic [127:0] i_aes_iter_core_key,
  output logic         o_aes_iter_core_valid,
  input  logic         i_aes_iter_core_ready,
  output logic [127:0] o_aes_iter_core_data_encrypted,
  output logic         o_aes_iter_core_busy
);

  localparam int NUM_CYCLES = (ROUNDS_PER_CYCLE > 0) ? (10 / ROUNDS_PER_CYCLE) : 0;
  localparam logic [3:0] RPC_W = 4'(ROUNDS_PER_CYCLE);

  // Only divisors of 10 give a whole number of RUN cycles.
  if (ROUNDS_PER_CYCLE < 1 || ROUNDS_PER_CYCLE > 10 ||
      NUM_CYCLES * ROUNDS_PER_CYCLE != 10) begin : g_bad_rpc
    $error("aes_iter_core: ROUNDS_PER_CYCLE must be 1, 2, 5 or 10");
  end

  // Forward S-box, byte 0 at the most significant end.
  localparam logic [0:2047] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  function automatic logic [7:0] f_sbox(input logic [7:0] b);
    return SBOX_TBL[int'(b) * 8 +: 8];
  endfunction

  function automatic logic [7:0] f_xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] f_sub_word(input logic [31:0] w);
    return {f_sbox(w[31:24]), f_sbox(w[23:16]), f_sbox(w[15:8]), f_sbox(w[7:0])};
  endfunction

  // One step of the AES-128 key schedule: four words from the previous four.
  function automatic logic [127:0] f_next_key(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] t, n0, n1, n2, n3;
    t  = f_sub_word({k[23:0], k[31:24]}) ^ {rc, 24'h000000};
    n0 = k[127:96] ^ t;
    n1 = k[95:64]  ^ n0;
    n2 = k[63:32]  ^ n1;
    n3 = k[31:0]   ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  function automatic logic [31:0] f_mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    a0 = c[31:24]; a1 = c[23:16]; a2 = c[15:8]; a3 = c[7:0];
    return {f_xtime(a0) ^ f_xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ f_xtime(a1) ^ f_xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ f_xtime(a2) ^ f_xtime(a3) ^ a3,
            f_xtime(a0) ^ a0 ^ a1 ^ a2 ^ f_xtime(a3)};
  endfunction

  // SubBytes, ShiftRows, optional MixColumns, AddRoundKey.
  function automatic logic [127:0] f_round(input logic [127:0] s, input logic [127:0] rk,
                                           input logic last);
    logic [7:0]   sb [16];
    logic [7:0]   sr [16];
    logic [31:0]  col;
    logic [127:0] mc;
    for (int unsigned i = 0; i < 16; i++) begin
      sb[i] = f_sbox(s[127 - 8 * i -: 8]);
    end
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        sr[c * 4 + r] = sb[((c + r) % 4) * 4 + r];
      end
    end
    mc = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      col = {sr[c * 4], sr[c * 4 + 1], sr[c * 4 + 2], sr[c * 4 + 3]};
      mc[127 - 32 * c -: 32] = last ? col : f_mix_col(col);
    end
    return mc ^ rk;
  endfunction

  state_t       r_fsm;
  logic [127:0] r_state;
  logic [127:0] r_rkey;
  logic [7:0]   r_rcon;
  logic [3:0]   r_cnt;
  logic [127:0] r_ct;
  logic         r_valid;
  logic         r_busy;

  logic         w_ready;
  logic         w_accept;
  logic         w_last_cycle;
  logic [127:0] w_st [ROUNDS_PER_CYCLE + 1];
  logic [127:0] w_rk [ROUNDS_PER_CYCLE + 1];
  logic [7:0]   w_rc [ROUNDS_PER_CYCLE + 1];

  assign w_ready      = (r_fsm == ST_IDLE) | ((r_fsm == ST_DONE) & i_aes_iter_core_ready);
  assign w_accept     = i_aes_iter_core_valid & w_ready;
  assign w_last_cycle = ((r_cnt + RPC_W) == 4'd10);

  assign w_st[0] = r_state;
  assign w_rk[0] = r_rkey;
  assign w_rc[0] = r_rcon;

  // Chain of rounds evaluated in one clock; the key schedule runs in lockstep.
  for (genvar g = 0; g < ROUNDS_PER_CYCLE; g++) begin : g_round
    logic [3:0] w_gidx;
    assign w_gidx      = r_cnt + 4'(g + 1);
    assign w_rk[g + 1] = f_next_key(w_rk[g], w_rc[g]);
    assign w_rc[g + 1] = f_xtime(w_rc[g]);
    assign w_st[g + 1] = f_round(w_st[g], w_rk[g + 1], w_gidx == 4'd10);
  end

  // Control FSM and datapath registers.
  // Acceptance is handled ahead of the case so IDLE and DONE share one load path.
  always_ff @(posedge i_aes_iter_core_clk or negedge i_aes_iter_core_rst_n) begin
    if (!i_aes_iter_core_rst_n) begin
      r_fsm   <= ST_IDLE;
      r_state <= '0;
      r_rkey  <= '0;
      r_rcon  <= 8'h01;
      r_cnt   <= '0;
      r_ct    <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
    end else if (w_accept) begin
      r_state <= i_aes_iter_core_plain_text ^ i_aes_iter_core_key;
      r_rkey  <= i_aes_iter_core_key;
      r_rcon  <= 8'h01;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b1;
      r_fsm   <= ST_RUN;
    end else begin
      unique case (r_fsm)
        ST_IDLE: ;
        ST_RUN: begin
          r_state <= w_st[ROUNDS_PER_CYCLE];
          r_rkey  <= w_rk[ROUNDS_PER_CYCLE];
          r_rcon  <= w_rc[ROUNDS_PER_CYCLE];
          r_cnt   <= r_cnt + RPC_W;
          if (w_last_cycle) begin
            r_ct    <= w_st[ROUNDS_PER_CYCLE];
            r_valid <= 1'b1;
            r_fsm   <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (i_aes_iter_core_ready) begin
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_fsm   <= ST_IDLE;
          end
        end
        default: begin
          r_fsm  <= ST_IDLE;
          r_busy <= 1'b0;
        end
      endcase
    end
  end

  assign o_aes_iter_core_ready          = w_ready;
  assign o_aes_iter_core_valid          = r_valid;
  assign o_aes_iter_core_data_encrypted = r_ct;
  assign o_aes_iter_core_busy           = r_busy;

endmodule

// File: tb/tb_aes_iter_core.sv
// Directed bench for aes_iter_core: four instances (1, 2, 5, 10 rounds per
// cycle) checked against FIPS-197 vectors, latency, backpressure,
// back-to-back acceptance, key change during RUN and reset mid-block.
module tb_aes_iter_core;

  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;

  logic         clk;
  logic         rst_n;
  logic [3:0]   s_vin, s_rdy_out, s_rdy_in, s_vout, s_busy;
  logic [127:0] s_pt  [4];
  logic [127:0] s_key [4];
  logic [127:0] s_ct  [4];

  int n_chk = 0;
  int n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar k = 0; k < 4; k++) begin : g_dut
    localparam int RPC = (k == 0) ? 1 : (k == 1) ? 2 : (k == 2) ? 5 : 10;
    aes_iter_core #(.ROUNDS_PER_CYCLE(RPC)) u_dut (
      .i_aes_iter_core_clk            (clk),
      .i_aes_iter_core_rst_n          (rst_n),
      .i_aes_iter_core_valid          (s_vin[k]),
      .o_aes_iter_core_ready          (s_rdy_out[k]),
      .i_aes_iter_core_plain_text     (s_pt[k]),
      .i_aes_iter_core_key            (s_key[k]),
      .o_aes_iter_core_valid          (s_vout[k]),
      .i_aes_iter_core_ready          (s_rdy_in[k]),
      .o_aes_iter_core_data_encrypted (s_ct[k]),
      .o_aes_iter_core_busy           (s_busy[k])
    );
  end

  // Bounded wait for o_valid; returns edges waited.
  task automatic wait_valid(input int k, input int budget, output int cycles, output bit ok);
    cycles = 0;
    ok     = 1'b0;
    while (cycles < budget && !ok) begin
      @(posedge clk); #1;
      cycles++;
      if (s_vout[k] === 1'b1) ok = 1'b1;
    end
  endtask

  // Present one block for exactly one edge (core must be ready).
  task automatic accept(input int k, input logic [127:0] pt, input logic [127:0] key);
    s_pt[k]  = pt;
    s_key[k] = key;
    s_vin[k] = 1'b1;
    @(posedge clk); #1;
    s_vin[k] = 1'b0;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    s_vin     = '0;
    s_rdy_in  = '1;
    for (int k = 0; k < 4; k++) begin
      s_pt[k]  = '0;
      s_key[k] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      n_chk++;
      if (s_vout[k] !== 1'b0 || s_rdy_out[k] !== 1'b1 || s_busy[k] !== 1'b0 || s_ct[k] !== '0) begin
        n_err++;
        $display("FAIL reset_%0d: got valid=%b ready=%b busy=%b ct=%h, want 0 1 0 0",
                 k, s_vout[k], s_rdy_out[k], s_busy[k], s_ct[k]);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_latency(input int k, input logic [127:0] pt, input logic [127:0] key,
                              input logic [127:0] exp_ct, input int lat, input string name);
    int cyc;
    bit ok;
    s_rdy_in[k] = 1'b1;
    accept(k, pt, key);
    n_chk++;
    if (s_busy[k] !== 1'b1 || s_rdy_out[k] !== 1'b0) begin
      n_err++;
      $display("FAIL %s_start: got busy=%b ready=%b, want 1 0", name, s_busy[k], s_rdy_out[k]);
    end
    wait_valid(k, 30, cyc, ok);
    n_chk++;
    if (!ok || cyc != lat) begin
      n_err++;
      $display("FAIL %s_latency: got %0d cycles (seen=%b), want %0d", name, cyc, ok, lat);
    end
    n_chk++;
    if (s_ct[k] !== exp_ct) begin
      n_err++;
      $display("FAIL %s_ct: got %h, want %h", name, s_ct[k], exp_ct);
    end
    @(posedge clk); #1;
    n_chk++;
    if (s_vout[k] !== 1'b0 || s_rdy_out[k] !== 1'b1 || s_busy[k] !== 1'b0) begin
      n_err++;
      $display("FAIL %s_drain: got valid=%b ready=%b busy=%b, want 0 1 0",
               name, s_vout[k], s_rdy_out[k], s_busy[k]);
    end
  endtask

  task automatic test_backpressure();
    int cyc;
    bit ok;
    s_rdy_in[0] = 1'b0;
    accept(0, C1_PT, C1_KEY);
    wait_valid(0, 30, cyc, ok);
    n_chk++;
    if (!ok || cyc != 10) begin
      n_err++;
      $display("FAIL bp_latency: got %0d cycles (seen=%b), want 10", cyc, ok);
    end
    s_pt[0]  = B_PT;
    s_key[0] = B_KEY;
    s_vin[0] = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      n_chk++;
      if (s_vout[0] !== 1'b1 || s_rdy_out[0] !== 1'b0 || s_ct[0] !== C1_CT) begin
        n_err++;
        $display("FAIL bp_hold_%0d: got valid=%b ready=%b ct=%h, want 1 0 %h",
                 i, s_vout[0], s_rdy_out[0], s_ct[0], C1_CT);
      end
    end
    s_rdy_in[0] = 1'b1;
    #1;
    n_chk++;
    if (s_rdy_out[0] !== 1'b1) begin
      n_err++;
      $display("FAIL bp_ready_follow: got ready=%b, want 1", s_rdy_out[0]);
    end
    @(posedge clk); #1;
    s_vin[0] = 1'b0;
    n_chk++;
    if (s_vout[0] !== 1'b0 || s_busy[0] !== 1'b1 || s_rdy_out[0] !== 1'b0) begin
      n_err++;
      $display("FAIL bp_accept: got valid=%b busy=%b ready=%b, want 0 1 0",
               s_vout[0], s_busy[0], s_rdy_out[0]);
    end
    wait_valid(0, 30, cyc, ok);
    n_chk++;
    if (!ok || cyc != 10 || s_ct[0] !== B_CT) begin
      n_err++;
      $display("FAIL bp_second: got %0d cycles ct=%h, want 10 %h", cyc, s_ct[0], B_CT);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int cyc1, cyc2;
    bit ok;
    s_rdy_in[0] = 1'b1;
    s_pt[0]     = C1_PT;
    s_key[0]    = C1_KEY;
    s_vin[0]    = 1'b1;
    @(posedge clk); #1;
    s_pt[0]  = B_PT;
    s_key[0] = B_KEY;
    wait_valid(0, 30, cyc1, ok);
    n_chk++;
    if (!ok || cyc1 != 10 || s_ct[0] !== C1_CT || s_rdy_out[0] !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_first: got %0d cycles ct=%h ready=%b, want 10 %h 1",
               cyc1, s_ct[0], s_rdy_out[0], C1_CT);
    end
    @(posedge clk); #1;
    s_vin[0] = 1'b0;
    n_chk++;
    if (s_vout[0] !== 1'b0 || s_busy[0] !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_accept: got valid=%b busy=%b, want 0 1", s_vout[0], s_busy[0]);
    end
    wait_valid(0, 30, cyc2, ok);
    n_chk++;
    if (!ok || cyc2 + 1 != 11 || s_ct[0] !== B_CT) begin
      n_err++;
      $display("FAIL b2b_second: got gap %0d ct=%h, want 11 %h", cyc2 + 1, s_ct[0], B_CT);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_key_change();
    int cyc;
    bit ok;
    s_rdy_in[0] = 1'b1;
    accept(0, C1_PT, C1_KEY);
    repeat (3) @(posedge clk);
    #1;
    s_key[0] = '1;
    s_pt[0]  = '1;
    wait_valid(0, 30, cyc, ok);
    n_chk++;
    if (!ok || cyc + 3 != 10 || s_ct[0] !== C1_CT) begin
      n_err++;
      $display("FAIL keychg: got %0d cycles ct=%h, want 10 %h", cyc + 3, s_ct[0], C1_CT);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    bit pulsed;
    s_rdy_in[0] = 1'b1;
    accept(0, C1_PT, C1_KEY);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (s_vout[0] !== 1'b0 || s_ct[0] !== '0 || s_rdy_out[0] !== 1'b1 || s_busy[0] !== 1'b0) begin
      n_err++;
      $display("FAIL rstmid: got valid=%b ct=%h ready=%b busy=%b, want 0 0 1 0",
               s_vout[0], s_ct[0], s_rdy_out[0], s_busy[0]);
    end
    #3;
    rst_n  = 1'b1;
    pulsed = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (s_vout[0] !== 1'b0) pulsed = 1'b1;
    end
    n_chk++;
    if (pulsed) begin
      n_err++;
      $display("FAIL rstmid_nopulse: got o_valid pulse after release, want none");
    end
    test_latency(0, C1_PT, C1_KEY, C1_CT, 10, "rstmid_c1");
  endtask

  initial begin
    test_reset();
    test_latency(0, C1_PT, C1_KEY, C1_CT, 10, "c1_rpc1");
    test_latency(1, B_PT,  B_KEY,  B_CT,  5,  "b_rpc2");
    test_latency(2, B_PT,  B_KEY,  B_CT,  2,  "b_rpc5");
    test_latency(3, B_PT,  B_KEY,  B_CT,  1,  "b_rpc10");
    test_latency(3, C1_PT, C1_KEY, C1_CT, 1,  "c1_rpc10");
    test_backpressure();
    test_back_to_back();
    test_key_change();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/aes_iter_core.md
Name: aes_iter_core

Overview:
Iterative AES-128 encryption core with a valid/ready handshake on both input and output. It is the area-scalable successor to the fully unrolled 10-stage pipeline. Rather than instantiating ten round stages, it reuses ROUNDS_PER_CYCLE combinational round instances over 10/ROUNDS_PER_CYCLE cycles. Round keys are expanded on the fly, so no 11-key schedule bank is stored.

Parameters:
ROUNDS_PER_CYCLE, 1, AES rounds evaluated per clock. Legal values are 1, 2, 5 and 10; any other value is an elaboration error.
NUM_CYCLES (localparam), 10/ROUNDS_PER_CYCLE, number of RUN cycles per block.

Ports:
i_aes_iter_core_clk  input  1  clock, rising edge.
i_aes_iter_core_rst_n  input  1  asynchronous reset, active low.
i_aes_iter_core_valid  input  1  plain text and key are valid.
o_aes_iter_core_ready  output  1  core can accept a block this cycle.
i_aes_iter_core_plain_text  input  128  plain text. Bits [127:120] are byte 0; the state is column-major, as in FIPS-197.
i_aes_iter_core_key  input  128  cipher key, same byte order.
o_aes_iter_core_valid  output  1  cipher text is valid.
i_aes_iter_core_ready  input  1  downstream accepts the cipher text.
o_aes_iter_core_data_encrypted  output  128  cipher text.
o_aes_iter_core_busy  output  1  high in RUN or DONE.

Behaviour:
- Clocking and reset: one clock. Reset is asynchronous and active-low. The clock and reset ports are named i_aes_iter_core_clk and i_aes_iter_core_rst_n.
- Reset values: FSM=IDLE; state, round key, cipher text output = 128'h0; round counter=0; rcon=8'h01; o_valid=0; o_busy=0; o_ready=1.
- FSM has three states: IDLE, RUN, DONE.
- IDLE:
  - o_ready=1.
  - On i_valid&o_ready: state <= plain_text ^ key (initial AddRoundKey); round key <= key; rcon <= 8'h01; counter <= 0; go to RUN.
  - i_valid low: stay in IDLE.
- RUN:
  - o_ready=0. Inputs are ignored.
  - Each cycle applies ROUNDS_PER_CYCLE chained rounds.
  - Each round: next round key derived from the previous one (RotWord, SubWord, xor with rcon on word 0, then the word xor chain); rcon advances by xtime (0x80 -> 0x1b); then SubBytes, ShiftRows, MixColumns, AddRoundKey.
  - The round with global index 10 omits MixColumns.
  - Counter increments by ROUNDS_PER_CYCLE. When the counter reaches 10, load the cipher text output register and go to DONE.
- DONE:
  - o_valid=1. Cipher text is held stable until i_ready.
  - On i_ready: o_valid drops.
  - If i_valid is also high in the same cycle, the new block is accepted (o_ready = i_ready in DONE) and the FSM goes directly to RUN.
  - Otherwise it returns to IDLE.
- Latency: o_valid rises exactly NUM_CYCLES clocks after the acceptance edge. Sustained throughput is one block per NUM_CYCLES+1 cycles.
- o_busy = (FSM != IDLE).
- o_ready is combinational from FSM and i_ready. There is no combinational path from i_valid to o_ready.
- Key changes:
  - The key is sampled only at acceptance. A key change during RUN has no effect on the block in flight.
  - Each accepted block may carry a different key. rcon and the round key restart at every acceptance.
- Reset mid-operation: the in-flight block is discarded and all registers return to their reset values. o_valid does not pulse after reset release.
- All datapath is combinational between registers. There are no multicycle paths.

Test Plan:
- FIPS-197 App. C.1, ROUNDS_PER_CYCLE=1: pt 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f, accepted at edge N -> o_valid rises at edge N+10, ct 69c4e0d86a7b0430d8cdb78070b4c55a.
- FIPS-197 App. B with ROUNDS_PER_CYCLE = 2, 5 and 10: pt 3243f6a8885a308d313198a2e0370734, key 2b7e151628aed2a6abf7158809cf4f3c -> ct 3925841d02dc09fbdc118597196a0b32 after 5, 2 and 1 cycles respectively.
- Backpressure: hold i_ready=0 for 7 cycles after o_valid -> ct stable, o_ready=0; a new i_valid is not accepted until i_ready=1.
- Back-to-back: i_valid held high with App. C.1 then App. B, i_ready=1 -> second block accepted in the same cycle as the first output handshake; both ct values are correct; second o_valid appears 11 cycles after the first (RPC=1).
- Key/input changed during RUN: drive key to all ones at cycle 3 of RUN -> output still equals the C.1 ct.
- Reset asserted at RUN cycle 4 -> o_valid=0, ct=0, o_ready=1 immediately. After release, the next C.1 block produces the correct ct with normal latency.
